// File: rtl/ifu_fetch.sv
// Instruction fetch unit: a single outstanding imem request,
// with a one-entry hold register toward IF/ID and redirect squashing.
module ifu_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_ready,
  output logic        pc_valid,
  output logic [63:0] IF_pc,
  output logic [31:0] IF_instr,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [63:0] r_fpc;
  logic        r_drop;
  logic        r_req;
  logic [63:0] r_pc;
  logic [31:0] r_instr;

  logic [63:0] w_tgt;
  logic        w_xfer;
  logic        w_capture;
  logic        w_release;

  assign w_tgt     = {redirect_pc[63:2], 2'b00};
  assign w_xfer    = (r_state == S_HOLD) && if_ready
                     && !redirect_valid;
  assign w_capture = (r_state == S_WAIT) && imem_rvalid
                     && !r_drop && !redirect_valid;
  assign w_release = (r_state == S_HOLD)
                     && (if_ready || redirect_valid);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: w_next = S_REQ;
      S_REQ: begin
        if (imem_gnt) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid)
          w_next = (r_drop || redirect_valid) ? S_REQ : S_HOLD;
      end
      S_HOLD: begin
        if (w_release) w_next = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_fpc   <= RESET_PC;
      r_drop  <= 1'b0;
      r_req   <= 1'b0;
      r_pc    <= RESET_PC;
      r_instr <= NOP_INST;
    end else begin
      r_state <= w_next;
      r_req   <= (w_next == S_REQ);
      if (redirect_valid)
        r_fpc <= w_tgt;
      else if (w_xfer)
        r_fpc <= r_fpc + 64'd4;
      // a grant taken alongside a redirect fetched the old target
      if (r_state == S_REQ && imem_gnt)
        r_drop <= redirect_valid;
      else if (r_state == S_WAIT)
        r_drop <= imem_rvalid ? 1'b0 : (r_drop || redirect_valid);
      if (w_capture) begin
        r_pc    <= r_fpc;
        r_instr <= imem_rdata;
      end else if (w_release) begin
        r_instr <= NOP_INST;
      end
    end
  end

  assign pc_valid  = (r_state == S_HOLD) && !redirect_valid;
  assign IF_pc     = r_pc;
  assign IF_instr  = r_instr;
  assign imem_req  = r_req;
  assign imem_addr = r_fpc;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: fetch stream, stall, redirects,
// address wrap and asynchronous reset.
module tb_ifu_fetch;

  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock;
  logic        reset;
  logic        if_ready;
  logic        pc_valid;
  logic [63:0] IF_pc;
  logic [31:0] IF_instr;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  int passed = 0;
  int total  = 0;

  ifu_fetch dut (
    .clock          (clock),
    .reset          (reset),
    .if_ready       (if_ready),
    .pc_valid       (pc_valid),
    .IF_pc          (IF_pc),
    .IF_instr       (IF_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_vld"},  {63'd0, pc_valid}, 64'd0);
    chk({tag, "_pc"},   IF_pc, RPC);
    chk({tag, "_ins"},  {32'd0, IF_instr}, {32'd0, NOP});
    chk({tag, "_req"},  {63'd0, imem_req}, 64'd0);
    chk({tag, "_addr"}, imem_addr, RPC);
  endtask

  // From REQ at address a: grant, 1-cycle response d, land in HOLD.
  task automatic do_fetch(input logic [63:0] a,
                          input logic [31:0] d);
    chk("f_req",  {63'd0, imem_req}, 64'd1);
    chk("f_addr", imem_addr, a);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    chk("f_wait_req", {63'd0, imem_req}, 64'd0);
    chk("f_wait_vld", {63'd0, pc_valid}, 64'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = d;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    chk("f_vld", {63'd0, pc_valid}, 64'd1);
    chk("f_pc",  IF_pc, a);
    chk("f_ins", {32'd0, IF_instr}, {32'd0, d});
  endtask

  initial begin
    reset          = 1'b1;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    tick();
    tick();
    chk_reset("rst");

    // release: IDLE cycle, then first request
    reset = 1'b0;
    settle();
    chk("idle_req", {63'd0, imem_req}, 64'd0);
    tick();
    do_fetch(64'h8000_0000, 32'h1111_1111);
    if_ready = 1'b1;
    tick();
    chk("xfer_ins", {32'd0, IF_instr}, {32'd0, NOP});
    do_fetch(64'h8000_0004, 32'h2222_2222);
    tick();
    do_fetch(64'h8000_0008, 32'h3333_3333);
    if_ready = 1'b0;

    // stall in HOLD with stray gnt/rvalid that must be ignored
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_BAD0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_vld", {63'd0, pc_valid}, 64'd1);
      chk("stall_pc",  IF_pc, 64'h8000_0008);
      chk("stall_ins", {32'd0, IF_instr}, 64'h3333_3333);
      chk("stall_req", {63'd0, imem_req}, 64'd0);
    end
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    if_ready    = 1'b1;
    tick();
    if_ready = 1'b0;
    chk("post_stall_addr", imem_addr, 64'h8000_000C);
    chk("post_stall_vld", {63'd0, pc_valid}, 64'd0);

    // redirect during WAIT, response 3 cycles later is dropped
    imem_gnt = 1'b1;
    tick();
    imem_gnt       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_1002;
    settle();
    chk("rw_vld", {63'd0, pc_valid}, 64'd0);
    tick();
    redirect_valid = 1'b0;
    chk("rw_req", {63'd0, imem_req}, 64'd0);
    tick();
    tick();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    chk("rw_ins", {32'd0, IF_instr}, {32'd0, NOP});
    chk("rw_vld2", {63'd0, pc_valid}, 64'd0);
    do_fetch(64'h8000_1000, 32'h4444_4444);

    // redirect in HOLD with if_ready: no transfer, no +4
    if_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_2000;
    settle();
    chk("rh_vld", {63'd0, pc_valid}, 64'd0);
    tick();
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    chk("rh_req",  {63'd0, imem_req}, 64'd1);
    chk("rh_addr", imem_addr, 64'h8000_2000);

    // ungranted request stays stable
    tick();
    chk("stable_req",  {63'd0, imem_req}, 64'd1);
    chk("stable_addr", imem_addr, 64'h8000_2000);

    // redirect together with grant: stale response dropped
    imem_gnt       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_3004;
    tick();
    imem_gnt       = 1'b0;
    redirect_valid = 1'b0;
    chk("rg_req", {63'd0, imem_req}, 64'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h57A1_E000;
    tick();
    imem_rvalid = 1'b0;
    chk("rg_vld", {63'd0, pc_valid}, 64'd0);
    chk("rg_ins", {32'd0, IF_instr}, {32'd0, NOP});
    do_fetch(64'h8000_3004, 32'h5555_5555);

    // 64-bit wrap of the fetch PC
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    do_fetch(64'hFFFF_FFFF_FFFF_FFFC, 32'h6666_6666);
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;
    chk("wrap_addr", imem_addr, 64'h0);
    chk("wrap_req",  {63'd0, imem_req}, 64'd1);

    // asynchronous reset while in WAIT
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    #3;
    reset = 1'b1;
    settle();
    chk_reset("arst");
    tick();
    reset       = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAAD_F00D;
    tick();
    chk("ar_req",  {63'd0, imem_req}, 64'd1);
    chk("ar_addr", imem_addr, RPC);
    tick();
    imem_rvalid = 1'b0;
    chk("ar_vld", {63'd0, pc_valid}, 64'd0);
    chk("ar_ins", {32'd0, IF_instr}, {32'd0, NOP});
    do_fetch(RPC, 32'h7777_7777);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000, PC loaded by reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013, instruction value driven while no valid fetch is held.
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high; asserting it forces every register to its reset value immediately, independent of clock.
REQ-005 if_ready  in  1  downstream IF/ID register accepts the offered fetch this cycle.
REQ-006 pc_valid  out  1  IF_pc/IF_instr hold a valid fetch.
REQ-007 IF_pc  out  64  PC of the offered instruction.
REQ-008 IF_instr  out  32  offered instruction.
REQ-009 redirect_valid  in  1  branch/exception redirect, single-cycle pulse, same cycle as downstream flush.
REQ-010 redirect_pc  in  64  redirect target; bits [1:0] are ignored and treated as zero.
REQ-011 imem_req  out  1  instruction-memory request.
REQ-012 imem_addr  out  64  request address, 4-byte aligned.
REQ-013 imem_gnt  in  1  memory accepts the request this cycle.
REQ-014 imem_rvalid  in  1  read data valid; at least 1 cycle after the grant.
REQ-015 imem_rdata  in  32  read data.

Function
REQ-016 The block SHALL keep at most one memory request outstanding.
REQ-017 States SHALL be IDLE, REQ, WAIT and HOLD, held in a fetch PC register and a 1-bit drop flag.
REQ-018 IDLE SHALL go to REQ on the next edge with no other action.
REQ-019 In REQ: imem_req=1 and imem_addr=fetch PC; on imem_gnt the state SHALL go to WAIT.
REQ-020 Until granted, imem_req and imem_addr SHALL stay stable, except after a redirect (REQ-027).
REQ-021 In WAIT with imem_rvalid and drop=0: IF_instr<=imem_rdata, IF_pc<=fetch PC, and the state SHALL go to HOLD.
REQ-022 In HOLD: pc_valid=1, and it SHALL be masked to 0 in any cycle where redirect_valid=1.
REQ-023 In HOLD, pc_valid & if_ready SHALL be a transfer: fetch PC<=fetch PC+4 (64-bit wrap-around, no overflow flag), state->REQ.
REQ-024 In HOLD without if_ready, IF_pc and IF_instr SHALL remain unchanged indefinitely.
REQ-025 pc_valid SHALL be 0 in IDLE, REQ and WAIT.
REQ-026 Latency from grant to pc_valid SHALL be 1 cycle after imem_rvalid; back-to-back throughput is one instruction per 3 cycles minimum with a 1-cycle memory.
REQ-027 On redirect_valid, fetch PC<=redirect_pc with bits [1:0] cleared, taking priority over +4 and over every other event; per state:
  - IDLE: state->REQ.
  - REQ, no gnt same cycle: state stays REQ; new address is driven from the next cycle.
  - REQ, gnt same cycle: granted request is stale; state->WAIT with drop=1.
  - WAIT, no rvalid: drop<=1; state stays WAIT.
  - WAIT, rvalid same cycle: response discarded; state->REQ.
  - HOLD: held instruction discarded, no transfer even if if_ready=1; state->REQ.
REQ-028 In WAIT with drop=1, imem_rvalid SHALL clear drop and move the state to REQ, with no update to IF_pc or IF_instr.
REQ-029 imem_rvalid outside WAIT SHALL be ignored.
REQ-030 imem_gnt outside REQ SHALL be ignored.

Reset
REQ-031 Reset values SHALL be: state=IDLE, fetch PC=RESET_PC, drop=0, pc_valid=0, IF_pc=RESET_PC, IF_instr=NOP_INST, imem_req=0, imem_addr=RESET_PC.
REQ-032 Reset asserted mid-transaction SHALL abandon the outstanding request, and any later imem_rvalid SHALL be treated as stale until the first new grant.
REQ-033 First imem_req after reset release SHALL occur in the second cycle (IDLE then REQ).

Verification
REQ-034 Reset release, 1-cycle memory, if_ready=1 -> addresses 0x80000000, 0x80000004, 0x80000008 fetched in order; each pc_valid pulse carries the matching rdata.
REQ-035 if_ready held 0 for 5 cycles in HOLD -> IF_pc/IF_instr constant and pc_valid=1 throughout; no new imem_req.
REQ-036 Redirect to 0x80001002 while in WAIT, rvalid 3 cycles later -> that response never reaches IF_instr; next request address 0x80001000.
REQ-037 Redirect in the same cycle as imem_gnt -> one stale response dropped; the next granted address is the target.
REQ-038 Redirect in HOLD with if_ready=1 -> pc_valid=0 that cycle; PC not incremented; next imem_addr equals the target.
REQ-039 Reset asserted asynchronously during WAIT -> outputs reach reset values without a clock edge; a stray rvalid after release is ignored.
